// File: rtl/udp_pkg.sv
// udp_pkg: shared UDP receive-path constants, FSM state encoding and length check
package udp_pkg;
  localparam int UDP_HDR_LEN     = 8;
  localparam int UDP_RAM_AW      = 11;
  localparam int UDP_MAX_PAYLOAD = 2048;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_DRAIN = 2'd2} udp_state_e;
  function automatic logic udp_len_ok(input logic [15:0] len);
    return len >= 16'(UDP_HDR_LEN + 1) && len <= 16'(UDP_MAX_PAYLOAD + UDP_HDR_LEN);
  endfunction
endpackage

// File: rtl/udp_sync_fifo.sv
// udp_sync_fifo: single-clock first-word-fall-through FIFO with synchronous clear
// ports: wr_en/wr_data push, rd_en pops rd_data (valid while !empty), count = occupancy
module udp_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 3,
  localparam int AW   = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic wr, rd;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  always_comb begin
    rd = rd_en && count_q != '0;
    wr = wr_en && (count_q != CW'(DEPTH) || rd);
    wr_ptr_d = clr ? '0 : wr ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = clr ? '0 : rd ? nxt(rd_ptr_q) : rd_ptr_q;
    count_d = clr ? '0 : count_q + CW'(wr) - CW'(rd);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) if (wr) mem_q[wr_ptr_q] <= wr_data;
  assign rd_data = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = count_q == '0;
endmodule

// File: rtl/udp_rx_unloader.sv
// udp_rx_unloader: streams a received UDP payload from the receive RAM as a valid/ready byte stream
// ports: udp_rec_* from the receive stage and RAM read port; m_* payload stream with last marker;
//        m_len payload length of the current packet; busy while streaming; pkt_drop rejected-packet pulse
module udp_rx_unloader
  import udp_pkg::*;
#(
  parameter int RAM_LAT    = 1,
  parameter int FIFO_DEPTH = RAM_LAT + 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  udp_rec_data_valid,
  input  logic [15:0]           udp_rec_data_length,
  output logic [UDP_RAM_AW-1:0] udp_rec_ram_read_addr,
  input  logic [7:0]            udp_rec_ram_rdata,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [11:0]           m_len,
  output logic                  busy,
  output logic                  pkt_drop
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  udp_state_e state_q, state_d;
  logic [11:0] m_len_q, m_len_d, rd_cnt_q, rd_cnt_d, beat_cnt_q, beat_cnt_d;
  logic [RAM_LAT-1:0] vld_q, vld_d;
  logic valid_d0_q, valid_d0_d, pkt_drop_q, pkt_drop_d;
  logic edge_e, accept, issue, xfer, fifo_empty;
  logic [7:0] fifo_dout;
  logic [CW-1:0] fifo_cnt;
  int infl;
  udp_sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (accept),
    .wr_en   (vld_q[RAM_LAT-1]),
    .wr_data (udp_rec_ram_rdata),
    .rd_en   (xfer),
    .rd_data (fifo_dout),
    .count   (fifo_cnt),
    .empty   (fifo_empty)
  );
  always_comb begin
    edge_e = udp_rec_data_valid && !valid_d0_q;
    accept = edge_e && state_q == ST_IDLE && udp_len_ok(udp_rec_data_length);
    m_valid = !fifo_empty;
    m_data = fifo_empty ? 8'h00 : fifo_dout;
    m_last = m_valid && beat_cnt_q == m_len_q - 12'd1;
    xfer = m_valid && m_ready;
    infl = 0;
    for (int i = 0; i < RAM_LAT; i++) infl += int'(vld_q[i]);
    // reads already in flight still need a FIFO slot when they land
    issue = state_q == ST_READ && rd_cnt_q < m_len_q && int'(fifo_cnt) + infl < FIFO_DEPTH;
    state_d = accept ? ST_READ
            : (state_q == ST_READ && rd_cnt_q == m_len_q) ? ST_DRAIN
            : (state_q == ST_DRAIN && xfer && m_last) ? ST_IDLE
            : state_q;
    m_len_d = accept ? udp_rec_data_length[11:0] - 12'(UDP_HDR_LEN) : m_len_q;
    rd_cnt_d = accept ? 12'd0 : issue ? rd_cnt_q + 12'd1 : rd_cnt_q;
    beat_cnt_d = accept ? 12'd0 : xfer ? beat_cnt_q + 12'd1 : beat_cnt_q;
    vld_d = RAM_LAT'({vld_q, issue});
    valid_d0_d = udp_rec_data_valid;
    pkt_drop_d = edge_e && !accept;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      m_len_q <= '0;
      rd_cnt_q <= '0;
      beat_cnt_q <= '0;
      vld_q <= '0;
      valid_d0_q <= 1'b0;
      pkt_drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_len_q <= m_len_d;
      rd_cnt_q <= rd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      vld_q <= vld_d;
      valid_d0_q <= valid_d0_d;
      pkt_drop_q <= pkt_drop_d;
    end
  end
  // rd_cnt is 12 bits so a 2048-byte payload ends at address 2047 without wrapping
  assign udp_rec_ram_read_addr = rd_cnt_q[UDP_RAM_AW-1:0];
  assign m_len = m_len_q;
  assign busy = state_q != ST_IDLE;
  assign pkt_drop = pkt_drop_q;
endmodule

// File: tb/tb_udp_rx_unloader.sv
// tb_udp_rx_unloader: scoreboard bench for udp_rx_unloader with a latency-matched RAM model
module tb_udp_rx_unloader;
  parameter int RAM_LAT = 1;
  logic clk = 0;
  logic rstn = 0;
  logic udp_rec_data_valid = 0;
  logic [15:0] udp_rec_data_length = 0;
  logic [10:0] udp_rec_ram_read_addr;
  logic [7:0] udp_rec_ram_rdata;
  logic [7:0] m_data;
  logic m_valid, m_last, busy, pkt_drop;
  logic m_ready = 1;
  logic [11:0] m_len;
  logic [7:0] mem [2048];
  logic [7:0] pipe [RAM_LAT];
  logic [8:0] exp_q [$];
  int checks = 0, errors = 0, cyc = 0, c0 = 0, cur_n = 0, first_cyc = 0;
  bit in_rst = 0, lat_armed = 0, full_rate = 1, rnd = 0, busy_chk = 0, prev_stall = 0;
  logic [7:0] prev_d;
  logic prev_l;

  udp_rx_unloader #(.RAM_LAT(RAM_LAT)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .udp_rec_data_valid    (udp_rec_data_valid),
    .udp_rec_data_length   (udp_rec_data_length),
    .udp_rec_ram_read_addr (udp_rec_ram_read_addr),
    .udp_rec_ram_rdata     (udp_rec_ram_rdata),
    .m_data                (m_data),
    .m_valid               (m_valid),
    .m_last                (m_last),
    .m_ready               (m_ready),
    .m_len                 (m_len),
    .busy                  (busy),
    .pkt_drop              (pkt_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    pipe[0] <= mem[udp_rec_ram_read_addr];
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign udp_rec_ram_rdata = pipe[RAM_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rstn && !in_rst) begin
      if (busy_chk) begin
        chk("busy_fall", busy, 0);
        busy_chk = 0;
      end
      if (prev_stall) begin
        chk("hold_v", m_valid, 1);
        chk("hold_d", m_data, prev_d);
        chk("hold_l", m_last, prev_l);
      end
      if (lat_armed && m_valid) begin
        chk("first_lat", cyc - c0, 2 + RAM_LAT);
        lat_armed = 0;
        first_cyc = cyc;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", m_valid, 0);
        else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("data", m_data, e[7:0]);
          chk("last", m_last, e[8]);
          if (e[8]) begin
            busy_chk = 1;
            if (full_rate) chk("rate", cyc - first_cyc, cur_n - 1);
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
    end
  end

  task automatic send(input int len, input bit drop);
    int n;
    n = len - 8;
    @(posedge clk);
    #1;
    if (!drop) begin
      for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, mem[i]});
      c0 = cyc;
      cur_n = n;
      lat_armed = 1;
    end
    udp_rec_data_valid = 1;
    udp_rec_data_length = 16'(len);
    @(negedge clk);
    @(negedge clk);
    chk("drop", pkt_drop, drop);
    if (!drop) chk("m_len", m_len, n);
    @(negedge clk);
    chk("drop_w", pkt_drop, 0);
    udp_rec_data_valid = 0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((exp_q.size() != 0 || busy) && k < 6000);
    chk("sb_empty", exp_q.size(), 0);
    chk("idle", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'(i >> 8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", udp_rec_ram_read_addr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_len", m_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", pkt_drop, 0);
    @(posedge clk);
    #1 rstn = 1;
    send(16, 0);
    wait_done();
    send(9, 0);
    wait_done();
    send(8, 1);
    repeat (6) @(negedge clk);
    chk("no_beat8", m_valid, 0);
    send(16'h0810, 1);
    repeat (6) @(negedge clk);
    chk("no_beat_big", m_valid, 0);
    chk("big_busy", busy, 0);
    send(2056, 0);
    wait_done();
    rnd = 1;
    full_rate = 0;
    send(40, 0);
    wait_done();
    rnd = 0;
    full_rate = 1;
    send(40, 0);
    repeat (5) @(posedge clk);
    send(20, 1);
    wait_done();
    send(40, 0);
    repeat (10) @(posedge clk);
    #1 rstn = 0;
    in_rst = 1;
    @(posedge clk);
    #1 rstn = 1;
    exp_q.delete();
    lat_armed = 0;
    busy_chk = 0;
    prev_stall = 0;
    @(negedge clk);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", udp_rec_ram_read_addr, 0);
    in_rst = 0;
    send(24, 0);
    wait_done();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
